// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for the bit-serial adder.
// The master side issues start/operands; the slave side (the adder) returns
// status and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry walks the
// operands LSB-first over WIDTH cycles. The partial sum builds up in an
// internal accumulator; sum/cout are updated only at the completion edge,
// so downstream logic never sees intermediate values.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [1:0]       fa_out;
  logic             accept;
  logic             last;

  // One-bit full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Full-adder cell inputs come straight from the shift-register LSBs.
  always_comb begin
    fa_out = full_add(sh_a[0], sh_b[0], carry);
  end

  // Next-state decode; a start is honoured only when not already running.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (cnt == LAST_BIT);
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand load, per-bit shift/accumulate and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= {WIDTH{1'b0}};
      sh_b     <= {WIDTH{1'b0}};
      carry    <= 1'b0;
      cnt      <= {CNT_W{1'b0}};
      acc      <= {WIDTH{1'b0}};
      bus.sum  <= {WIDTH{1'b0}};
      bus.cout <= 1'b0;
    end else if (accept) begin
      sh_a  <= bus.a;
      sh_b  <= bus.b;
      carry <= bus.cin;
      cnt   <= {CNT_W{1'b0}};
      acc   <= {WIDTH{1'b0}};
    end else if (state == RUN) begin
      sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
      carry <= fa_out[1];
      acc   <= {fa_out[0], acc[WIDTH-1:1]};
      if (last) begin
        // Counter stays at the last index instead of wrapping; the next
        // accept reloads it anyway.
        bus.sum  <= {fa_out[0], acc[WIDTH-1:1]};
        bus.cout <= fa_out[1];
      end else begin
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_next == RUN);
      bus.done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the scenario tests
// and a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one 8-bit add and watch 14 edges; optionally disturb start and
  // operands at the third cycle of the run.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [8:0] exp, input bit disturb);
    int first;
    int pulses;
    logic [8:0] res;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(bus8.busy), 32'd1);
    first = 0; pulses = 0; res = 9'd0;
    for (int k = 1; k <= 14; k++) begin
      if (disturb && k == 3) begin
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
      end
      if (disturb && k == 4) bus8.start = 1'b0;
      @(posedge clk); #1;
      if (k < 8 && bus8.busy !== 1'b1) check({tag, "_busy_drop"}, 32'(k), 32'd8);
      if (bus8.done) begin
        pulses++;
        if (first == 0) begin
          first = k;
          res = {bus8.cout, bus8.sum};
        end
      end
    end
    check({tag, "_latency"}, 32'(first), 32'd8);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_result"}, 32'(res), 32'(exp));
    check({tag, "_persist"}, 32'({bus8.cout, bus8.sum}), 32'(exp));
    check({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
  endtask

  initial begin
    int first;
    int second;
    int pulses;
    int busy_cnt;
    logic [8:0] r1;
    logic [8:0] r2;
    n_tests = 0;
    n_fail  = 0;

    // Reset held with start high: nothing may launch.
    rst = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_sum", 32'(bus8.sum), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    rst = 1'b0;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    check("rst_no_start", 32'(bus8.busy), 32'd0);

    // Directed additions.
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    run_op("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0);
    run_op("12_34", 8'h12, 8'h34, 1'b0, 9'h046, 1'b0);
    run_op("disturb", 8'h0F, 8'h01, 1'b0, 9'h010, 1'b1);

    // Abort with reset in the fourth cycle of a run; start asserted alongside.
    bus8.a = 8'h33; bus8.b = 8'h44; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus8.start = 1'b0;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_sum", 32'(bus8.sum), 32'd0);
    check("abort_cout", 32'(bus8.cout), 32'd0);
    pulses = 0; busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus8.done) pulses++;
      if (bus8.busy) busy_cnt++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_no_busy", 32'(busy_cnt), 32'd0);

    // Back-to-back: start held high through the DONE cycle.
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    first = 0; second = 0; pulses = 0; r1 = 9'd0; r2 = 9'd0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        pulses++;
        if (first == 0) begin
          first = k;
          r1 = {bus8.cout, bus8.sum};
          bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b1;
        end else if (second == 0) begin
          second = k;
          r2 = {bus8.cout, bus8.sum};
          bus8.start = 1'b0;
        end
      end
    end
    bus8.start = 1'b0;
    check("b2b_first_lat", 32'(first), 32'd8);
    check("b2b_second_lat", 32'(second), 32'd17);
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_res1", 32'(r1), 32'h003);
    check("b2b_res2", 32'(r2), 32'h101);

    // 4-bit sweep; each new op is launched in the previous op's DONE cycle.
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          int edges;
          bus4.a = 4'(x); bus4.b = 4'(y); bus4.cin = 1'(c); bus4.start = 1'b1;
          @(posedge clk); #1;
          bus4.start = 1'b0;
          edges = 0;
          while (bus4.done !== 1'b1 && edges < 10) begin
            @(posedge clk); #1;
            edges++;
          end
          check("w4_latency", 32'(edges), 32'd4);
          check("w4_result", 32'({bus4.cout, bus4.sum}), 32'(x + y + c));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial multi-bit adder built around a single 1-bit full-adder cell with a registered carry. It feeds operand bits LSB-first into the cell and consumes the cell's sum/carry outputs each cycle. It accumulates the result and holds it for downstream logic. It trades latency (WIDTH cycles) for area compared with a ripple-carry array of full adders.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled high in IDLE or DONE launches an addition
a  input  WIDTH  operand A; sampled only on the accepting start edge
b  input  WIDTH  operand B; sampled only on the accepting start edge
cin  input  1  carry-in; sampled only on the accepting start edge
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  one-cycle pulse: sum/cout just updated with a new result
sum  output  WIDTH  result of a+b+cin, low WIDTH bits; held between operations
cout  output  1  carry-out of the MSB; held between operations

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset takes priority over every other event.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and bit counter are all 0.
- States: IDLE, RUN, DONE. All outputs are registered; there is no combinational path from input to output.
- IDLE, start=1 at edge E0:
  - load shA<=a, shB<=b, c<=cin, cnt<=0, acc<=0;
  - go to RUN; busy=1 from E0.
- IDLE, start=0: hold.
- RUN, each edge:
  - bit = shA[0]^shB[0]^c;
  - c <= (shA[0]&shB[0]) | (shA[0]&c) | (shB[0]&c);
  - acc <= {bit, acc[WIDTH-1:1]}; shA and shB shift right by 1, zero-fill; cnt <= cnt+1.
- RUN, edge where cnt==WIDTH-1 (edge E_WIDTH):
  - last bit is processed;
  - sum <= final acc including this bit; cout <= final carry;
  - go to DONE; busy=0, done=1.
- Latency: done is high in the cycle after edge E_WIDTH, exactly WIDTH edges after start was sampled.
- DONE: done=1 for exactly one cycle.
  - If start=0, go to IDLE and done=0 next cycle.
  - If start=1, accept back-to-back: same load as IDLE, go to RUN, done=0, busy=1.
- start=1 during RUN is ignored. It is not queued.
- Changes on a, b and cin during RUN have no effect on the in-flight result.
- sum and cout change only at the completion edge or on reset. Intermediate partial results never appear on sum.
- Arithmetic: {cout,sum} == a + b + cin, exact for all inputs (modulo 2^(WIDTH+1), so never truncated).
- rst=1 mid-RUN: the operation is aborted, all outputs go to reset values and no done pulse is produced. A start in the same cycle as rst is ignored.
- cnt is sized $clog2(WIDTH) bits. It never wraps inside an operation.

Test Plan:
1. Reset: assert rst 2 cycles with start=1 -> busy=0, done=0, sum=0, cout=0; no operation starts.
2. WIDTH=8, a=8'hFF, b=8'h01, cin=0, start 1 cycle -> busy high 8 cycles; then done pulses 1 cycle with sum=8'h00, cout=1; values persist afterwards.
3. WIDTH=8, a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
4. Mid-operation disturbance: start a=8'h0F, b=8'h01, cin=0. On cycle 3 pulse start and flip a/b/cin -> start and input changes ignored; sum=8'h10, cout=0 at the original done time; only one done pulse.
5. Abort and back-to-back: rst at cycle 4 of a run -> no done, outputs 0, IDLE. Then start held high across a DONE cycle -> second op begins in DONE cycle, next done exactly 8 edges later.
6. Exhaustive WIDTH=4: all a, b, cin (512 cases) -> {cout,sum} == a+b+cin every time; done spacing = 4 edges.
